crypto_wallet2_nios_po_tx_value: RTL and testbench
==================================================

// Module: crypto_wallet2_nios_po_tx_value
// PURPOSE
//  Avalon-MM slave output port: the Nios core writes 8-bit values, which are
//  queued and handed to external fabric over a valid/ready stream.
//  Output-direction counterpart of the PIO input capture ports. Sits on the
//  Nios data master next to them, feeding values into the wallet datapath.
//  Provides status, flow control and a transfer counter so firmware can pace writes.
// PARAMETERS
//  DATA_W     8   width of out_data and of the DATA register
//  DEPTH      4   FIFO entries; power of 2, minimum 2
//  CNT_W      16  width of SENT_COUNT; wraps modulo 2**CNT_W
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  reset      in   1       asynchronous, active-high; clears all state
//  address    in   2       word address: 0 DATA, 1 STATUS, 2 CONTROL, 3 SENT_COUNT
//  chipselect in   1       slave select
//  write_n    in   1       active-low write strobe, qualified by chipselect
//  writedata  in   32      write data; upper bits ignored where unused
//  readdata   out  32      registered read data, 1-cycle latency
//  out_data   out  DATA_W  FIFO head value
//  out_valid  out  1       out_data holds a value for the consumer
//  out_ready  in   1       consumer accepts; transfer completes when out_valid & out_ready at posedge
// BEHAVIOUR
//  Reset (async): readdata=0, out_valid=0, out_data=0, FIFO empty, CONTROL=0, overflow=0, SENT_COUNT=0.
//  wr = chipselect & ~write_n.
//  readdata is loaded every clk from the address mux, regardless of chipselect. Unused bits read 0.
//  DATA (0): wr pushes writedata[DATA_W-1:0] if not full. Read returns the last accepted value.
//  Write when full: value dropped, STATUS.overflow set.
//    Applies even if a pop happens in the same cycle; fullness is sampled before the pop.
//  STATUS (1), read: [0] empty, [1] full, [2] overflow (sticky), [3] out_valid.
//    Write: writing 1 to bit 2 clears overflow. A clear and a new overflow in the same cycle leaves it set.
//  CONTROL (2), R/W: [0] enable, [1] irq_en (see CONFIGURATION). Other bits read 0.
//  SENT_COUNT (3): read returns the count. Any write clears it.
//    A write and a completed transfer in the same cycle give 0 (the clear wins).
//  Stream rules:
//    out_valid = ~empty & (enable | hold).
//    hold is set at a posedge when out_valid & ~out_ready, and cleared on a completed transfer.
//    Once out_valid rises, it and out_data stay stable until a transfer completes,
//    even if enable drops or firmware writes the FIFO.
//    out_data = FIFO head; reads 0 when empty.
//  Latency: a DATA write at edge N into an empty FIFO with enable=1 gives out_valid=1 after edge N.
//    Back-to-back transfers run at 1 per clk while out_ready=1.
//  Push and pop in the same cycle with 0<count<DEPTH: both occur, count is unchanged.
//  Pointers: log2(DEPTH) bits plus 1 wrap bit.
//    full  = pointer MSBs differ and the low bits are equal.
//    empty = pointers are equal.
//  A transfer increments SENT_COUNT. FFF..F + 1 wraps to 0.
//  Reset mid-transfer: FIFO flushed, out_valid drops immediately. The consumer must tolerate this.
// CONFIGURATION
//  CRYPTO_WALLET2_PO_IRQ_EN defined: adds port irq (out, 1 bit), registered, reset 0.
//    irq = CONTROL.irq_en & (empty | overflow), updated each clk.
//  Undefined: no irq port, CONTROL[1] reads 0 and writes to it are ignored.
// STRUCTURE
//  Package crypto_wallet2_nios_po_pkg holds:
//    register address constants (ADDR_DATA/STATUS/CONTROL/COUNT);
//    STATUS bit indices (ST_EMPTY/FULL/OVF/VALID);
//    CONTROL bit indices (CT_EN/CT_IRQ_EN).
//  Sub-module crypto_wallet2_nios_po_fifo: sync FIFO with push/pop/full/empty/head, parameters DATA_W and DEPTH.
//  The top level holds the register file, the hold flag, the counter and the read mux.
// TESTING
//  Reset; read all 4 regs -> readdata 0 for each.
//    STATUS reads 0x1 (empty); out_valid=0.
//  enable=1, out_ready=1, write 0xA5 to DATA -> out_valid=1, out_data=0xA5 for 1 clk.
//    Then SENT_COUNT=1 and STATUS=0x1.
//  enable=1, out_ready=0, write 5 values -> first 4 queued, full=1, overflow=1.
//    Then out_ready=1 -> 4 transfers in order on consecutive clks; SENT_COUNT=4.
//  out_valid=1 with out_ready=0, then clear enable -> out_valid and out_data stay stable.
//    One transfer completes on out_ready=1; no further out_valid until enable=1.
//  Preload SENT_COUNT to 0xFFFF via 65535 transfers, one more transfer -> reads 0.
//    Write to SENT_COUNT during a transfer -> reads 0.
//  Assert reset with 3 entries queued and out_valid=1 -> out_valid=0 before the next edge.
//    After release, STATUS=0x1.
//    With CRYPTO_WALLET2_PO_IRQ_EN, irq=1 one clk after irq_en is set.

Source files
------------

// File: rtl/crypto_wallet2_nios_po_tx_value_pkg.sv
// Register map and bit positions shared by the Nios output port and its bench.
package crypto_wallet2_nios_po_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;
    localparam logic [1:0] ADDR_COUNT   = 2'd3;

    localparam int unsigned ST_EMPTY = 0;
    localparam int unsigned ST_FULL  = 1;
    localparam int unsigned ST_OVF   = 2;
    localparam int unsigned ST_VALID = 3;

    localparam int unsigned CT_EN     = 0;
    localparam int unsigned CT_IRQ_EN = 1;

endpackage

// File: rtl/crypto_wallet2_nios_po_tx_value_if.sv
// Avalon-MM slave bus plus the outgoing valid/ready stream of the output port.
interface crypto_wallet2_nios_po_tx_value_if #(
    parameter int unsigned DATA_W = 8
);
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  address, chipselect, write_n, writedata, out_ready,
        output readdata, out_data, out_valid
    );

    modport master (
        output address, chipselect, write_n, writedata, out_ready,
        input  readdata, out_data, out_valid
    );
endinterface

// File: rtl/crypto_wallet2_nios_po_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads 0 while empty.
module crypto_wallet2_nios_po_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/crypto_wallet2_nios_po_tx_value.sv
// Nios Avalon-MM output port: queues written bytes onto a valid/ready stream.
// Optional irq output when CRYPTO_WALLET2_PO_IRQ_EN is defined.
module crypto_wallet2_nios_po_tx_value
    import crypto_wallet2_nios_po_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk,
    input  logic reset,
`ifdef CRYPTO_WALLET2_PO_IRQ_EN
    output logic irq,
`endif
    crypto_wallet2_nios_po_tx_value_if.slave bus
);
    logic              wr, push_req, push, pop;
    logic              full, empty, valid;
    logic              enable, irq_en, hold, overflow;
    logic [DATA_W-1:0] head, last_data;
    logic [CNT_W-1:0]  sent_count;
    logic [31:0]       rd_next;

    assign wr       = bus.chipselect & ~bus.write_n;
    assign push_req = wr && (bus.address == ADDR_DATA);
    assign push     = push_req & ~full;
    assign valid    = ~empty & (enable | hold);
    assign pop      = valid & bus.out_ready;

    assign bus.out_valid = valid;
    assign bus.out_data  = head;

    crypto_wallet2_nios_po_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (bus.writedata[DATA_W-1:0]),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Register file, hold flag and transfer counter; clears take priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable     <= 1'b0;
            hold       <= 1'b0;
            overflow   <= 1'b0;
            last_data  <= '0;
            sent_count <= '0;
        end else begin
            if (wr && bus.address == ADDR_CONTROL) enable <= bus.writedata[CT_EN];
            if (pop)                          hold <= 1'b0;
            else if (valid && !bus.out_ready) hold <= 1'b1;
            if (push_req && full) overflow <= 1'b1;
            else if (wr && bus.address == ADDR_STATUS && bus.writedata[ST_OVF]) overflow <= 1'b0;
            if (push) last_data <= bus.writedata[DATA_W-1:0];
            if (wr && bus.address == ADDR_COUNT) sent_count <= '0;
            else if (pop)                        sent_count <= sent_count + CNT_W'(1);
        end
    end

`ifdef CRYPTO_WALLET2_PO_IRQ_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr && bus.address == ADDR_CONTROL) irq_en <= bus.writedata[CT_IRQ_EN];
            irq <= irq_en & (empty | overflow);
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_comb begin
        rd_next = '0;
        case (bus.address)
            ADDR_DATA:    rd_next = 32'(last_data);
            ADDR_STATUS: begin
                rd_next[ST_EMPTY] = empty;
                rd_next[ST_FULL]  = full;
                rd_next[ST_OVF]   = overflow;
                rd_next[ST_VALID] = valid;
            end
            ADDR_CONTROL: begin
                rd_next[CT_EN]     = enable;
                rd_next[CT_IRQ_EN] = irq_en;
            end
            default:      rd_next = 32'(sent_count);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.readdata <= '0;
        else       bus.readdata <= rd_next;
    end
endmodule

// File: tb/tb_crypto_wallet2_nios_po_tx_value.sv
// Directed bench for the Nios output port; define CRYPTO_WALLET2_PO_IRQ_EN to cover irq.
module tb_crypto_wallet2_nios_po_tx_value;
    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef CRYPTO_WALLET2_PO_IRQ_EN
    logic irq;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    crypto_wallet2_nios_po_tx_value_if #(.DATA_W(8)) bus ();

    crypto_wallet2_nios_po_tx_value dut (
        .clk   (clk),
        .reset (reset),
`ifdef CRYPTO_WALLET2_PO_IRQ_EN
        .irq   (irq),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, input string tag, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        @(posedge clk);
        #1;
        bus.chipselect = 1'b0;
        check_eq(tag, bus.readdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] fill [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        bus.out_ready  = 1'b0;
        #1;
        check_eq("rst_readdata", bus.readdata, 32'h0);
        check_eq("rst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("rst_data", 32'(bus.out_data), 32'h0);
        #11 reset = 1'b0;

        bus_read(2'd0, "rst_rd_data", 32'h0);
        bus_read(2'd1, "rst_rd_status", 32'h1);
        bus_read(2'd2, "rst_rd_control", 32'h0);
        bus_read(2'd3, "rst_rd_count", 32'h0);

        // single transfer with the consumer ready
        bus.out_ready = 1'b1;
        bus_write(2'd2, 32'h1);
        bus_write(2'd0, 32'hA5);
        check_eq("one_valid", 32'(bus.out_valid), 32'h1);
        check_eq("one_data", 32'(bus.out_data), 32'hA5);
        idle(1);
        check_eq("one_valid_drop", 32'(bus.out_valid), 32'h0);
        bus_read(2'd3, "one_count", 32'h1);
        bus_read(2'd1, "one_status", 32'h1);
        bus_read(2'd0, "one_lastdata", 32'hA5);

        // fill past capacity with the consumer stalled, then drain
        bus_write(2'd3, 32'h0);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bus_write(2'd0, 32'(fill[i]));
        bus_write(2'd0, 32'h55);
        bus_read(2'd1, "ovf_status", 32'hE);
        bus_read(2'd0, "ovf_lastdata", 32'h44);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_valid", 32'(bus.out_valid), 32'h1);
            check_eq("drain_data", 32'(bus.out_data), 32'(fill[i]));
            idle(1);
        end
        check_eq("drain_empty", 32'(bus.out_valid), 32'h0);
        bus_read(2'd3, "drain_count", 32'h4);
        bus_write(2'd1, 32'h4);
        bus_read(2'd1, "ovf_clear", 32'h1);

        // hold keeps the presented value while enable drops
        bus.out_ready = 1'b0;
        bus_write(2'd0, 32'h77);
        check_eq("hold_valid0", 32'(bus.out_valid), 32'h1);
        bus_write(2'd2, 32'h0);
        check_eq("hold_valid1", 32'(bus.out_valid), 32'h1);
        check_eq("hold_data1", 32'(bus.out_data), 32'h77);
        bus_write(2'd0, 32'h88);
        check_eq("hold_data2", 32'(bus.out_data), 32'h77);
        bus.out_ready = 1'b1;
        idle(1);
        check_eq("hold_after_xfer", 32'(bus.out_valid), 32'h0);
        idle(2);
        check_eq("hold_disabled", 32'(bus.out_valid), 32'h0);
        bus_write(2'd2, 32'h1);
        check_eq("reenable_valid", 32'(bus.out_valid), 32'h1);
        check_eq("reenable_data", 32'(bus.out_data), 32'h88);
        idle(1);
        check_eq("reenable_drain", 32'(bus.out_valid), 32'h0);

        // counter wrap and clear-versus-increment priority
        bus_write(2'd3, 32'h0);
        for (int i = 0; i < 65535; i++) bus_write(2'd0, 32'(i & 8'hFF));
        idle(1);
        bus_read(2'd3, "count_max", 32'hFFFF);
        bus_write(2'd0, 32'h12);
        idle(1);
        bus_read(2'd3, "count_wrap", 32'h0);
        bus_write(2'd0, 32'h34);
        bus_write(2'd3, 32'h0);
        idle(1);
        bus_read(2'd3, "count_clear_wins", 32'h0);

        // asynchronous reset while presenting a value
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus_write(2'd0, 32'(fill[i]));
        check_eq("prereset_valid", 32'(bus.out_valid), 32'h1);
        #3 reset = 1'b1;
        #1;
        check_eq("midrst_valid", 32'(bus.out_valid), 32'h0);
        check_eq("midrst_readdata", bus.readdata, 32'h0);
        #2 reset = 1'b0;
        bus_read(2'd1, "postrst_status", 32'h1);
        bus_read(2'd2, "postrst_control", 32'h0);

`ifdef CRYPTO_WALLET2_PO_IRQ_EN
        check_eq("irq_off", 32'(irq), 32'h0);
        bus_write(2'd2, 32'h2);
        idle(1);
        check_eq("irq_on", 32'(irq), 32'h1);
        bus_read(2'd2, "irq_en_rd", 32'h2);
`else
        bus_write(2'd2, 32'h2);
        bus_read(2'd2, "irq_en_ignored", 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
